distance: RTL and testbench

DISTANCE -- requirements
Module: distance

---
 rtl/distance_pkg.sv | 20 ++
 rtl/distance_isqrt_stage.sv | 42 ++++
 rtl/distance.sv | 85 ++++++++
 tb/tb_distance.sv | 120 ++++++++++++
 4 files changed

// File: rtl/distance_pkg.sv
// Shared widths and latency for the distance pipeline, plus the absolute-difference helper.
package distance_pkg;

  localparam int COORD_W    = 8;
  localparam int PROD_W     = 2 * COORD_W;
  localparam int SQ_W       = 17;
  localparam int ROOT_W     = 9;
  localparam int RES_W      = 32;
  localparam int LATENCY    = 12;
  localparam int PRE_STAGES = 3;
  localparam int SQ_ALIGN   = LATENCY - PRE_STAGES;
  // Wide enough for (root << 9) + (1 << 16) without overflow.
  localparam int TRIAL_W    = SQ_W + 3;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/distance_isqrt_stage.sv
// One registered iteration of the restoring square root: decides root bit BIT.
module isqrt_stage
  import distance_pkg::*;
#(
  parameter int BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SQ_W-1:0]   rem_i,
  input  logic [ROOT_W-1:0] root_i,
  output logic [SQ_W-1:0]   rem_o,
  output logic [ROOT_W-1:0] root_o
);

  logic [TRIAL_W-1:0] trial;
  logic [SQ_W-1:0]    rem_d;
  logic [ROOT_W-1:0]  root_d;

  // trial = (root + 2^BIT)^2 - root^2, the cost of setting this bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rem_d  = rem_i;
    root_d = root_i;
    trial  = (TRIAL_W'(root_i) << (BIT + 1)) + (TRIAL_W'(1) << (2 * BIT));
    if (TRIAL_W'(rem_i) >= trial) begin
      rem_d  = rem_i - trial[SQ_W-1:0];
      root_d = root_i | (ROOT_W'(1) << BIT);
    end
  end

  // NOTE: state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_o  <= '0;
      root_o <= '0;
    end else begin
      rem_o  <= rem_d;
      root_o <= root_d;
    end
  end

endmodule

// File: rtl/distance.sv
// Fully pipelined floor Euclidean distance, 12-cycle latency.
// Define DISTANCE_SQ_OUT_EN to add the aligned sum-of-squares output sq.
module distance
  import distance_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic [RES_W-1:0]   res
`ifdef DISTANCE_SQ_OUT_EN
  ,
  output logic [RES_W-1:0]   sq
`endif
);

  logic [COORD_W-1:0] dx_q, dy_q, dx_d, dy_d;
  logic [PROD_W-1:0]  sqx_q, sqy_q, sqx_d, sqy_d;
  logic [SQ_W-1:0]    sum_q, sum_d;

  always_comb begin
    dx_d  = abs_diff(x1, x2);
    dy_d  = abs_diff(y1, y2);
    sqx_d = PROD_W'(dx_q) * PROD_W'(dx_q);
    sqy_d = PROD_W'(dy_q) * PROD_W'(dy_q);
    sum_d = SQ_W'(sqx_q) + SQ_W'(sqy_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q  <= '0;
      dy_q  <= '0;
      sqx_q <= '0;
      sqy_q <= '0;
      sum_q <= '0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      sqx_q <= sqx_d;
      sqy_q <= sqy_d;
      sum_q <= sum_d;
    end
  end

  // Index 0 is the stage-3 sum; index k holds the result after k root bits.
  logic [SQ_W-1:0]   rem_c  [0:ROOT_W];
  logic [ROOT_W-1:0] root_c [0:ROOT_W];

  assign rem_c[0]  = sum_q;
  assign root_c[0] = '0;

  for (genvar i = 0; i < ROOT_W; i++) begin : g_sqrt
    isqrt_stage #(
      .BIT (ROOT_W - 1 - i)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .rem_i  (rem_c[i]),
      .root_i (root_c[i]),
      .rem_o  (rem_c[i+1]),
      .root_o (root_c[i+1])
    );
  end

  assign res = RES_W'(root_c[ROOT_W]);

`ifdef DISTANCE_SQ_OUT_EN
  logic [SQ_W-1:0] sq_pipe_q [SQ_ALIGN];

  // NOTE: this delay line is flushed by reset like every other pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQ_ALIGN; i++) sq_pipe_q[i] <= '0;
    end else begin
      sq_pipe_q[0] <= sum_q;
      for (int i = 1; i < SQ_ALIGN; i++) sq_pipe_q[i] <= sq_pipe_q[i-1];
    end
  end

  assign sq = RES_W'(sq_pipe_q[SQ_ALIGN-1]);
`endif

endmodule

// File: tb/tb_distance.sv
// Directed bench for distance: hand-computed results checked cycle by cycle against a latency map.
module tb_distance;
  import distance_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [COORD_W-1:0] x1, y1, x2, y2;
  logic [RES_W-1:0]   res;
`ifdef DISTANCE_SQ_OUT_EN
  logic [RES_W-1:0]   sq;
`endif

  distance dut (
    .clk (clk),
    .rst (rst),
    .x1  (x1),
    .y1  (y1),
    .x2  (x2),
    .y2  (y2),
    .res (res)
`ifdef DISTANCE_SQ_OUT_EN
    ,
    .sq  (sq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_res_a [int];
  int exp_sq_a  [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one input set at the negedge, record its hand-computed result LATENCY edges ahead,
  // advance one cycle and check whatever is due now (0 when nothing is due).
  task automatic step(input int a, input int b, input int c, input int d,
                      input int e_res, input int e_sq);
    x1 = 8'(a);
    y1 = 8'(b);
    x2 = 8'(c);
    y2 = 8'(d);
    exp_res_a[cyc + LATENCY] = e_res;
    exp_sq_a[cyc + LATENCY]  = e_sq;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check($sformatf("res@%0d", cyc), res,
          exp_res_a.exists(cyc) ? 32'(exp_res_a[cyc]) : 32'd0);
`ifdef DISTANCE_SQ_OUT_EN
    check($sformatf("sq@%0d", cyc), sq,
          exp_sq_a.exists(cyc) ? 32'(exp_sq_a[cyc]) : 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7, 9, 7, 9, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    x1 = '0; y1 = '0; x2 = 8'd3; y2 = 8'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_res", res, 32'd0);
    rst = 1'b0;

    // Single vector: zeros for 11 edges, then 5 on the 12th, then the idle zero.
    step(0, 0, 3, 4, 5, 25);
    idle(13);

    // Back-to-back stream.
    step(0, 0, 30, 40, 50, 2500);
    step(0, 0, 100, 100, 141, 20000);
    step(3, 4, 0, 0, 5, 25);
    step(0, 0, 300, 400, 150, 22672);
    step(0, 0, 640, 480, 257, 66560);
    step(0, 0, 255, 255, 360, 130050);
    step(7, 9, 7, 9, 0, 0);
    step(200, 10, 50, 90, 170, 28900);
    step(50, 90, 200, 10, 170, 28900);
    step(1, 1, 2, 2, 1, 2);
    step(0, 0, 1, 2, 2, 5);
    step(10, 0, 0, 24, 26, 676);
    step(255, 255, 0, 0, 360, 130050);
    step(44, 144, 0, 0, 150, 22672);
    step(0, 0, 30, 40, 50, 2500);
    step(30, 40, 0, 0, 50, 2500);
    step(100, 100, 0, 0, 141, 20000);

    // Mid-flight reset: output is nonzero now and more results are queued behind it.
    check("pre_reset_nonzero", 32'(res != 0), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_async", res, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", res, 32'd0);
    rst = 1'b0;
    exp_res_a.delete();
    exp_sq_a.delete();

    // Flushed results must never reappear; then a fresh vector emerges normally.
    idle(14);
    step(3, 4, 0, 0, 5, 25);
    idle(13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
